seq_controller: RTL and testbench

- Multi-cycle stage sequencer for the Y86-64 SEQ datapath (fetch, register_file, execute, memory, pc_update).
- Owns the architectural PC and status registers.
- Issues one-cycle stage-enable strobes in order, waits on data-memory handshake, and stops on halt or any exception.
- Sits above the datapath, replacing free-running PC feedback with an explicit, resettable, steppable control loop.

---
 rtl/seq_pkg.sv | 56 +++++
 rtl/seq_mem_wait_timer.sv | 35 +++
 rtl/seq_controller.sv | 176 +++++++++++++++++
 tb/tb_seq_controller.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the Y86-64 SEQ stage sequencer: status codes,
// instruction codes, sequencer states and the registered control bundle.
package seq_pkg;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_EXECUTE   = 4'd3,
    S_MEMORY    = 4'd4,
    S_MEM_WAIT  = 4'd5,
    S_WRITEBACK = 4'd6,
    S_PCUPD     = 4'd7,
    S_STEP_WAIT = 4'd8,
    S_HALT      = 4'd9
  } state_e;

  typedef struct packed {
    logic fetch_en;
    logic decode_en;
    logic execute_en;
    logic mem_en;
    logic wb_en;
    logic pc_en;
    logic busy;
    logic halted;
  } ctrl_t;

  function automatic logic is_mem_icode(input logic [3:0] ic);
    logic r;
    case (ic)
      I_RMMOVQ, I_MRMOVQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: r = 1'b1;
      default:                                            r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seq_mem_wait_timer.sv
// Counts data-memory wait cycles; timeout is high once the count reaches
// MEM_TIMEOUT. load restarts the count at 1, inc advances it (saturating).
module seq_mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic inc,
  output logic timeout
);

  localparam logic [7:0] LIMIT = 8'(MEM_TIMEOUT);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = 8'd1;
    end else if (inc && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= 8'd0;
    else     cnt_q <= cnt_d;
  end

  assign timeout = (cnt_q == LIMIT);

endmodule

// File: rtl/seq_controller.sv
// Y86-64 SEQ stage sequencer: owns PC and status, issues one stage strobe per
// cycle. Optional performance counters are built when SEQ_PERF_CNT_EN is defined.
module seq_controller
  import seq_pkg::*;
#(
  parameter logic [63:0] RESET_PC    = 64'd0,
  parameter int          MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        step_mode,
  input  logic        step_req,
  input  logic [3:0]  icode,
  input  logic        instr_valid,
  input  logic        imem_error,
  input  logic        dmem_error,
  input  logic        mem_ready,
  input  logic [63:0] updated_pc,
  output logic [63:0] pc,
  output logic        fetch_en,
  output logic        decode_en,
  output logic        execute_en,
  output logic        mem_en,
  output logic        wb_en,
  output logic        pc_en,
  output logic [2:0]  stat,
  output logic        busy,
  output logic        halted
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instr_cnt
`endif
);

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [2:0]  stat_q, stat_d;
  ctrl_t       ctrl_q, ctrl_d;
  logic        mem_timeout_s;

  seq_mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (state_q == S_MEMORY),
    .inc     (state_q == S_MEM_WAIT),
    .timeout (mem_timeout_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      stat_q  <= STAT_AOK;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      stat_q  <= stat_d;
      ctrl_q  <= ctrl_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    stat_d  = stat_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
        else       state_d = S_IDLE;
      end
      S_FETCH: begin
        if (imem_error) begin
          stat_d  = STAT_ADR;
          state_d = S_HALT;
        end else if (!instr_valid) begin
          stat_d  = STAT_INS;
          state_d = S_HALT;
        end else if (icode == I_HALT) begin
          stat_d  = STAT_HLT;
          state_d = S_HALT;
        end else begin
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = S_EXECUTE;
      S_EXECUTE: begin
        if (is_mem_icode(icode)) state_d = S_MEMORY;
        else                     state_d = S_WRITEBACK;
      end
      S_MEMORY, S_MEM_WAIT: begin
        // The timeout only applies once waiting; MEMORY always loads the timer.
        if (dmem_error) begin
          stat_d  = STAT_ADR;
          state_d = S_HALT;
        end else if (mem_ready) begin
          state_d = S_WRITEBACK;
        end else if ((state_q == S_MEM_WAIT) && mem_timeout_s) begin
          stat_d  = STAT_ADR;
          state_d = S_HALT;
        end else begin
          state_d = S_MEM_WAIT;
        end
      end
      S_WRITEBACK: state_d = S_PCUPD;
      S_PCUPD: begin
        pc_d = updated_pc;
        if (step_mode) state_d = S_STEP_WAIT;
        else           state_d = S_FETCH;
      end
      S_STEP_WAIT: begin
        if (step_req || !step_mode) state_d = S_FETCH;
        else                        state_d = S_STEP_WAIT;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes are decoded from the next state so they are registered yet Moore-timed.
  always_comb begin
    ctrl_d = '0;
    case (state_d)
      S_FETCH:     begin ctrl_d.fetch_en   = 1'b1; ctrl_d.busy = 1'b1; end
      S_DECODE:    begin ctrl_d.decode_en  = 1'b1; ctrl_d.busy = 1'b1; end
      S_EXECUTE:   begin ctrl_d.execute_en = 1'b1; ctrl_d.busy = 1'b1; end
      S_MEMORY:    begin ctrl_d.mem_en     = 1'b1; ctrl_d.busy = 1'b1; end
      S_MEM_WAIT:  ctrl_d.busy = 1'b1;
      S_WRITEBACK: begin ctrl_d.wb_en      = 1'b1; ctrl_d.busy = 1'b1; end
      S_PCUPD:     begin ctrl_d.pc_en      = 1'b1; ctrl_d.busy = 1'b1; end
      S_HALT:      ctrl_d.halted = 1'b1;
      default:     ctrl_d = '0;
    endcase
  end

  assign pc         = pc_q;
  assign stat       = stat_q;
  assign fetch_en   = ctrl_q.fetch_en;
  assign decode_en  = ctrl_q.decode_en;
  assign execute_en = ctrl_q.execute_en;
  assign mem_en     = ctrl_q.mem_en;
  assign wb_en      = ctrl_q.wb_en;
  assign pc_en      = ctrl_q.pc_en;
  assign busy       = ctrl_q.busy;
  assign halted     = ctrl_q.halted;

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [31:0] instr_cnt_q, instr_cnt_d;

  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    instr_cnt_d = instr_cnt_q;
    if (ctrl_q.busy && (cycle_cnt_q != 32'hFFFF_FFFF)) cycle_cnt_d = cycle_cnt_q + 32'd1;
    else                                                cycle_cnt_d = cycle_cnt_q;
    if ((state_q == S_PCUPD) && (instr_cnt_q != 32'hFFFF_FFFF)) instr_cnt_d = instr_cnt_q + 32'd1;
    else                                                         instr_cnt_d = instr_cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt_q <= 32'd0;
      instr_cnt_q <= 32'd0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  assign cycle_cnt = cycle_cnt_q;
  assign instr_cnt = instr_cnt_q;
`endif

endmodule

// File: tb/tb_seq_controller.sv
// Directed self-checking bench for seq_controller (default build, no perf counters).
module tb_seq_controller;

  localparam logic [63:0] RST_PC = 64'h0000_0000_0000_1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, step_mode = 1'b0, step_req = 1'b0;
  logic [3:0]  icode = 4'h1;
  logic        instr_valid = 1'b1, imem_error = 1'b0, dmem_error = 1'b0, mem_ready = 1'b0;
  logic [63:0] updated_pc = 64'd0;
  logic [63:0] pc;
  logic        fetch_en, decode_en, execute_en, mem_en, wb_en, pc_en, busy, halted;
  logic [2:0]  stat;

  int total = 0;
  int bad = 0;

  seq_controller #(.RESET_PC(RST_PC), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .start(start), .step_mode(step_mode), .step_req(step_req),
    .icode(icode), .instr_valid(instr_valid), .imem_error(imem_error),
    .dmem_error(dmem_error), .mem_ready(mem_ready), .updated_pc(updated_pc),
    .pc(pc), .fetch_en(fetch_en), .decode_en(decode_en), .execute_en(execute_en),
    .mem_en(mem_en), .wb_en(wb_en), .pc_en(pc_en), .stat(stat), .busy(busy),
    .halted(halted)
  );

  always #5 clk = ~clk;

  // {fetch, decode, execute, mem, wb, pc}
  function automatic logic [5:0] strb();
    return {fetch_en, decode_en, execute_en, mem_en, wb_en, pc_en};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0; step_mode = 1'b0; step_req = 1'b0; icode = 4'h1;
    instr_valid = 1'b1; imem_error = 1'b0; dmem_error = 1'b0; mem_ready = 1'b0;
    updated_pc = 64'd0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    total++;
    if ({pc, stat, strb(), busy, halted} !== {RST_PC, 3'd1, 6'b0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_state: got pc=%h stat=%0d strb=%b busy=%b halted=%b expected pc=%h stat=1 strb=0 busy=0 halted=0",
               pc, stat, strb(), busy, halted, RST_PC);
    end
  endtask

  task automatic test_nop();
    logic [5:0] exp [5] = '{6'b100000, 6'b010000, 6'b001000, 6'b000010, 6'b000001};
    do_reset();
    icode = 4'h1; updated_pc = 64'h0000_0000_0000_1004; start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start = 1'b0;
      total++;
      if (strb() !== exp[i] || busy !== 1'b1) begin
        bad++;
        $display("FAIL nop_strobe[%0d]: got %b busy=%b expected %b busy=1", i, strb(), busy, exp[i]);
      end
      if (i == 4) icode = 4'h0;
    end
    @(negedge clk);
    total++;
    if (strb() !== 6'b100000 || pc !== 64'h1004 || stat !== 3'd1) begin
      bad++;
      $display("FAIL nop_refetch: got strb=%b pc=%h stat=%0d expected 100000 pc=1004 stat=1", strb(), pc, stat);
    end
    @(negedge clk);
    total++;
    if (stat !== 3'd2 || halted !== 1'b1 || busy !== 1'b0 || strb() !== 6'b0 || pc !== 64'h1004) begin
      bad++;
      $display("FAIL halt_icode: got stat=%0d halted=%b busy=%b strb=%b pc=%h expected stat=2 halted=1 busy=0 strb=0 pc=1004",
               stat, halted, busy, strb(), pc);
    end
    start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    total++;
    if (halted !== 1'b1 || strb() !== 6'b0 || stat !== 3'd2) begin
      bad++;
      $display("FAIL halt_sticky: got halted=%b strb=%b stat=%0d expected halted=1 strb=0 stat=2", halted, strb(), stat);
    end
  endtask

  task automatic test_mem_wait();
    logic [5:0] exp [9] = '{6'b100000, 6'b010000, 6'b001000, 6'b000100,
                            6'b000000, 6'b000000, 6'b000000, 6'b000010, 6'b000001};
    do_reset();
    icode = 4'h5; updated_pc = 64'h0000_0000_0000_0040; start = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      start = 1'b0;
      total++;
      if (strb() !== exp[i] || busy !== 1'b1) begin
        bad++;
        $display("FAIL mem_strobe[%0d]: got %b busy=%b expected %b busy=1", i, strb(), busy, exp[i]);
      end
      mem_ready = (i == 6);
    end
    @(negedge clk);
    total++;
    if (strb() !== 6'b100000 || pc !== 64'h40 || stat !== 3'd1) begin
      bad++;
      $display("FAIL mem_next_fetch: got strb=%b pc=%h stat=%0d expected 100000 pc=40 stat=1", strb(), pc, stat);
    end
  endtask

  task automatic test_timeout();
    logic [5:0] exp [8] = '{6'b100000, 6'b010000, 6'b001000, 6'b000100,
                            6'b000000, 6'b000000, 6'b000000, 6'b000000};
    do_reset();
    icode = 4'h4; updated_pc = 64'h0000_0000_0000_0777; start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      start = 1'b0;
      total++;
      if (strb() !== exp[i] || busy !== 1'b1 || stat !== 3'd1) begin
        bad++;
        $display("FAIL timeout_seq[%0d]: got %b busy=%b stat=%0d expected %b busy=1 stat=1", i, strb(), busy, stat, exp[i]);
      end
    end
    @(negedge clk);
    total++;
    if (stat !== 3'd3 || halted !== 1'b1 || busy !== 1'b0 || strb() !== 6'b0 || pc !== RST_PC) begin
      bad++;
      $display("FAIL timeout_halt: got stat=%0d halted=%b busy=%b strb=%b pc=%h expected stat=3 halted=1 busy=0 strb=0 pc=%h",
               stat, halted, busy, strb(), pc, RST_PC);
    end
  endtask

  task automatic test_fetch_priority();
    do_reset();
    imem_error = 1'b1; instr_valid = 1'b0; icode = 4'h0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    total++;
    if (stat !== 3'd3 || halted !== 1'b1 || pc !== RST_PC) begin
      bad++;
      $display("FAIL prio_adr: got stat=%0d halted=%b pc=%h expected stat=3 halted=1 pc=%h", stat, halted, pc, RST_PC);
    end
    do_reset();
    instr_valid = 1'b0; icode = 4'h0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    total++;
    if (stat !== 3'd4 || halted !== 1'b1) begin
      bad++;
      $display("FAIL prio_ins: got stat=%0d halted=%b expected stat=4 halted=1", stat, halted);
    end
  endtask

  task automatic test_step();
    do_reset();
    step_mode = 1'b1; icode = 4'h1; updated_pc = 64'h0000_0000_0000_2000; start = 1'b1;
    repeat (5) @(negedge clk);
    start = 1'b0;
    total++;
    if (strb() !== 6'b000001) begin
      bad++;
      $display("FAIL step_pcupd: got %b expected 000001", strb());
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (strb() !== 6'b0 || busy !== 1'b0 || pc !== 64'h2000) begin
        bad++;
        $display("FAIL step_wait[%0d]: got strb=%b busy=%b pc=%h expected strb=0 busy=0 pc=2000", i, strb(), busy, pc);
      end
    end
    updated_pc = 64'h0000_0000_0000_3000; step_req = 1'b1;
    @(negedge clk);
    step_req = 1'b0;
    total++;
    if (strb() !== 6'b100000) begin
      bad++;
      $display("FAIL step_resume: got %b expected 100000", strb());
    end
    repeat (5) @(negedge clk);
    total++;
    if (strb() !== 6'b0 || pc !== 64'h3000) begin
      bad++;
      $display("FAIL step_second: got strb=%b pc=%h expected strb=0 pc=3000", strb(), pc);
    end
    step_mode = 1'b0;
    @(negedge clk);
    total++;
    if (strb() !== 6'b100000) begin
      bad++;
      $display("FAIL step_clear: got %b expected 100000", strb());
    end
  endtask

  task automatic test_rst_mid();
    do_reset();
    icode = 4'h1; updated_pc = 64'h0000_0000_0000_5000; start = 1'b1;
    repeat (8) @(negedge clk);
    start = 1'b0;
    total++;
    if (strb() !== 6'b001000 || pc !== 64'h5000) begin
      bad++;
      $display("FAIL rst_mid_pre: got strb=%b pc=%h expected 001000 pc=5000", strb(), pc);
    end
    #1 rst = 1'b1;
    #1;
    total++;
    if ({pc, stat, strb(), busy, halted} !== {RST_PC, 3'd1, 6'b0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL rst_async: got pc=%h stat=%0d strb=%b busy=%b halted=%b expected pc=%h stat=1 strb=0 busy=0 halted=0",
               pc, stat, strb(), busy, halted, RST_PC);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (strb() !== 6'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rst_idle: got strb=%b busy=%b expected strb=0 busy=0", strb(), busy);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (strb() !== 6'b100000 || pc !== RST_PC) begin
      bad++;
      $display("FAIL rst_restart: got strb=%b pc=%h expected 100000 pc=%h", strb(), pc, RST_PC);
    end
  endtask

  initial begin
    test_reset();
    test_nop();
    test_mem_wait();
    test_timeout();
    test_fetch_priority();
    test_step();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
